adxl362_activity_ctrl: RTL and testbench
========================================

# adxl362_activity_ctrl

Activity/inactivity detector and interrupt router for the ADXL362 behavioural model. It consumes each new X/Y/Z sample from the accelerometer, applies the threshold and time registers under ACT_INACT_CTL control, and sequences the awake/asleep state machine. It latches the ACT/INACT/AWAKE status bits for the STATUS register and drives INT1/INT2 through the INTMAP1/INTMAP2 masks. It sits between `adxl362_accelerometer`, `adxl362_regs` and the top-level INT pins.

## Interface
- No parameters.
- `clk_16mhz`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `sample_valid`  in  1  one-cycle pulse per ODR sample; X/Y/Z valid in that cycle.
- `xdata`, `ydata`, `zdata`  in  12 each  signed two's-complement samples.
- `threshold_active`  in  11  unsigned activity threshold (LSB = 1 sample LSB).
- `time_active`  in  8  required consecutive active samples.
- `threshold_inactive`  in  11  unsigned inactivity threshold.
- `time_inactive`  in  16  required consecutive inactive samples.
- `act_inact_ctrl`  in  8  bit0 ACT_EN, bit1 ACT_REF, bit2 INACT_EN, bit3 INACT_REF, bits5:4 LINKLOOP (00/10 default, 01 linked, 11 loop).
- `intmap1`, `intmap2`  in  8 each  bit0 DATA_READY, bit4 ACT, bit5 INACT, bit6 AWAKE, bit7 INT_LOW; other bits ignored.
- `data_ready`  in  1  current STATUS data-ready bit.
- `status_read`  in  1  one-cycle pulse when the host reads STATUS.
- `act_flag`, `inact_flag`, `awake`  out  1 each  STATUS bits 4, 5, 6.
- `int1`, `int2`  out  1 each  interrupt pin levels.

## Operation
- Magnitude: |a| is a 12-bit unsigned value, and |-2048| = 2048. The threshold is zero-extended to 12 bits.
- Active sample: any axis |a| > threshold_active, strictly greater.
- Inactive sample: all axes |a| < threshold_inactive, strictly less.
- Counters:
  - The activity counter is 8-bit; the inactivity counter is 16-bit.
  - On each `sample_valid`, a counter increments if its condition holds and clears to 0 if it does not. Counters saturate at all-ones.
  - An event fires when the post-increment count ≥ max(time, 1), so time 0 behaves as time 1.
  - A counter is held at 0 while its enable bit is 0.
- Default mode (LINKLOOP 00/10):
  - Activity and inactivity are detected independently.
  - An event sets its flag; the flag stays set until `status_read`.
  - `awake` is held at 1.
  - After an event fires, its counter clears.
- Linked mode (01):
  - The FSM has two states. S_AWAKE: only inactivity is evaluated, `awake`=1. S_ASLEEP: only activity is evaluated, `awake`=0.
  - Inactivity event: set `inact_flag`, go to S_ASLEEP. Activity event: set `act_flag`, go to S_AWAKE.
  - While the flag of the last event is still set (not yet acknowledged by `status_read`), no further evaluation occurs and counters hold at 0.
- Loop mode (11): same FSM as linked mode, with two differences. No acknowledge is needed. Each transition clears the opposite flag.
- Setting or clearing a flag:
  - `sample_valid` and `status_read` in the same cycle: the set wins, and the flag that is not being set clears.
  - Changing LINKLOOP forces the FSM to S_AWAKE and clears both counters. Flags are unchanged.
- Interrupts:
  - intN_raw = |(intmapN[6:0] & {AWAKE, INACT, ACT, 0, 0, 0, DATA_READY}).
  - intN = intN_raw ^ intmapN[7].

## Timing
- Reset values: `act_flag`=0, `inact_flag`=0, `awake`=1, FSM=S_AWAKE, counters=0. `int1`/`int2` = intmapN[7], which evaluates to the value after reset.
- Flags, `awake` and FSM update on the edge closing the `sample_valid` cycle (latency 1).
- `int1`/`int2` are registered: latency 1 after the flag, data_ready or intmap change.
- `status_read` clears a flag on the following edge.
- Reset asserted mid-count discards all progress. The first sample after release starts a fresh count.

## Configuration
- `ADXL362_REFERENCED_EN` defined:
  - ACT_REF/INACT_REF select referenced mode, which compares |a − ref| per axis instead of |a|. Use a 13-bit difference, saturated to 12 bits.
  - ref is captured from the current sample when the relevant enable rises, and after every event of that type.
- Not defined: the REF bits are ignored, only absolute compare is performed, and no reference registers exist.

## Structure
- Bit positions for ACT_INACT_CTL, INTMAP and STATUS, plus the LINKLOOP encodings and FSM state encodings, go in the shared `adxl362_defines.vh` include alongside the register addresses.
- One natural sub-module, `adxl362_event_counter`, instantiated twice (activity, inactivity). It contains:
  - the per-axis magnitude/threshold compare (including the reference path when `ADXL362_REFERENCED_EN` is defined);
  - the consecutive-sample counter with its width as a parameter;
  - the event pulse output.

## Test plan
- Default mode, threshold_active=100, time_active=3, ACT_EN=1. Drive x=101 for 3 samples: `act_flag`=1 on the 3rd, and `int1`=1 one cycle later with intmap1=0x10. x=100 (not strictly greater) never fires.
- Inactivity with time_inactive=0. One sample with all axes at 10 and threshold_inactive=20 sets `inact_flag` after 1 sample (time 0 behaves as time 1).
- Linked mode. Inactivity: `awake` goes 0. Further active samples are ignored until `status_read`, after which 2 active samples with time_active=2 set `act_flag` and return `awake`=1.
- Loop mode. Alternating act/inact events toggle `awake` with no `status_read`, and each transition clears the opposite flag.
- Simultaneous event and `status_read`: the event flag stays 1. x=-2048 with threshold 2047 counts as active.
- `reset_n`=0 mid-count (2 of 3 samples): after release, 3 fresh samples are needed. intmap1=0x80 makes `int1`=1 while idle.

Source files
------------

// File: rtl/adxl362_activity_ctrl_pkg.sv
// Shared bit positions, encodings and helpers for the ADXL362 activity/inactivity controller.
package adxl362_activity_ctrl_pkg;

   // ACT_INACT_CTL bit positions
   localparam int AIC_ACT_EN    = 0;
   localparam int AIC_ACT_REF   = 1;
   localparam int AIC_INACT_EN  = 2;
   localparam int AIC_INACT_REF = 3;
   localparam int AIC_LL_LSB    = 4;

   // INTMAP bit positions; STATUS uses the same positions for DR/ACT/INACT/AWAKE
   localparam int IM_DATA_READY = 0;
   localparam int IM_ACT        = 4;
   localparam int IM_INACT      = 5;
   localparam int IM_AWAKE      = 6;
   localparam int IM_INT_LOW    = 7;

   typedef enum logic [1:0] {
      LL_DEFAULT     = 2'b00,
      LL_LINKED      = 2'b01,
      LL_DEFAULT_ALT = 2'b10,
      LL_LOOP        = 2'b11
   } linkloop_e;

   typedef enum logic {
      S_AWAKE  = 1'b0,
      S_ASLEEP = 1'b1
   } act_state_e;

   // |-2048| wraps to 12'h800, which read unsigned is exactly 2048
   function automatic logic [11:0] mag12(input logic [11:0] v);
      return v[11] ? (~v + 12'd1) : v;
   endfunction

   function automatic logic irq_level(input logic [7:0] map, input logic dr,
                                      input logic act, input logic inact,
                                      input logic awake);
      logic [6:0] src;
      src                = '0;
      src[IM_DATA_READY] = dr;
      src[IM_ACT]        = act;
      src[IM_INACT]      = inact;
      src[IM_AWAKE]      = awake;
      return (|(map[6:0] & src)) ^ map[IM_INT_LOW];
   endfunction

endpackage

// File: rtl/adxl362_activity_ctrl_if.sv
// Sample, register and status/interrupt bundle between the activity controller and its neighbours.
interface adxl362_activity_ctrl_if;
   logic               sample_valid;
   logic signed [11:0] xdata;
   logic signed [11:0] ydata;
   logic signed [11:0] zdata;
   logic [10:0]        threshold_active;
   logic [7:0]         time_active;
   logic [10:0]        threshold_inactive;
   logic [15:0]        time_inactive;
   logic [7:0]         act_inact_ctrl;
   logic [7:0]         intmap1;
   logic [7:0]         intmap2;
   logic               data_ready;
   logic               status_read;
   logic               act_flag;
   logic               inact_flag;
   logic               awake;
   logic               int1;
   logic               int2;

   modport master (
      output sample_valid, xdata, ydata, zdata,
      output threshold_active, time_active, threshold_inactive, time_inactive,
      output act_inact_ctrl, intmap1, intmap2, data_ready, status_read,
      input  act_flag, inact_flag, awake, int1, int2
   );

   modport slave (
      input  sample_valid, xdata, ydata, zdata,
      input  threshold_active, time_active, threshold_inactive, time_inactive,
      input  act_inact_ctrl, intmap1, intmap2, data_ready, status_read,
      output act_flag, inact_flag, awake, int1, int2
   );
endinterface

// File: rtl/adxl362_event_counter.sv
// Per-axis threshold compare plus consecutive-sample counter; fires a one-cycle event pulse.
// ADXL362_REFERENCED_EN adds per-axis reference registers and |a - ref| compare.
module adxl362_event_counter
   import adxl362_activity_ctrl_pkg::*;
#(
   parameter int CNT_W        = 8,
   parameter bit DETECT_ABOVE = 1'b1
)(
   input  logic               clk_16mhz,
   input  logic               reset_n,
   input  logic               sample_valid,
   input  logic signed [11:0] xdata,
   input  logic signed [11:0] ydata,
   input  logic signed [11:0] zdata,
   input  logic [10:0]        threshold,
   input  logic [CNT_W-1:0]   time_req,
   input  logic               enable,
   input  logic               evaluate,
   input  logic               clear,
   input  logic               ref_mode,
   output logic               event_pulse
);
   logic [2:0][11:0]  smp;
   logic [2:0][11:0]  mag;
   logic [2:0]        over, under;
   logic [11:0]       thr12;
   logic              hit;
   logic [CNT_W-1:0]  cnt, cnt_inc, time_min;

   assign smp   = {zdata, ydata, xdata};
   assign thr12 = {1'b0, threshold};

`ifdef ADXL362_REFERENCED_EN
   logic [2:0][11:0] ref_q;
   logic             en_q;

   always_ff @(posedge clk_16mhz) begin
      if (!reset_n) begin
         en_q  <= 1'b0;
         ref_q <= '0;
      end else begin
         en_q <= enable;
         if ((enable && !en_q) || event_pulse) ref_q <= smp;
      end
   end
`else
   logic unused_ref;
   assign unused_ref = enable ^ ref_mode;
`endif

   for (genvar i = 0; i < 3; i++) begin : g_axis
`ifdef ADXL362_REFERENCED_EN
      logic [12:0] diff, dmag;
      assign diff   = {smp[i][11], smp[i]} - {ref_q[i][11], ref_q[i]};
      assign dmag   = diff[12] ? (~diff + 13'd1) : diff;
      assign mag[i] = ref_mode ? ((dmag > 13'd4095) ? 12'hFFF : dmag[11:0])
                               : mag12(smp[i]);
`else
      assign mag[i] = mag12(smp[i]);
`endif
      assign over[i]  = mag[i] > thr12;
      assign under[i] = mag[i] < thr12;
   end

   assign hit = DETECT_ABOVE ? (|over) : (&under);

   // time 0 behaves as time 1
   assign cnt_inc     = (&cnt) ? cnt : cnt + CNT_W'(1);
   assign time_min    = (time_req == '0) ? CNT_W'(1) : time_req;
   assign event_pulse = sample_valid && evaluate && !clear && hit && (cnt_inc >= time_min);

   always_ff @(posedge clk_16mhz) begin
      if (!reset_n || clear || !evaluate) cnt <= '0;
      else if (sample_valid)              cnt <= (hit && !event_pulse) ? cnt_inc : '0;
   end

endmodule

// File: rtl/adxl362_activity_ctrl.sv
// Activity/inactivity detector, awake/asleep sequencer and INT1/INT2 router.
// ADXL362_REFERENCED_EN enables referenced (|a - ref|) compare inside the event counters.
module adxl362_activity_ctrl
   import adxl362_activity_ctrl_pkg::*;
(
   input  logic                   clk_16mhz,
   input  logic                   reset_n,
   adxl362_activity_ctrl_if.slave bus
);
   act_state_e state, state_nxt;
   logic [1:0] linkloop, linkloop_q;
   logic       mode_chg, linked, looped;
   logic       act_eval, inact_eval, act_evt, inact_evt;
   logic       act_q, inact_q, act_nxt, inact_nxt;
   logic       int1_q, int2_q;
   logic       unused_ctrl;

   assign linkloop    = bus.act_inact_ctrl[AIC_LL_LSB +: 2];
   assign linked      = (linkloop == LL_LINKED);
   assign looped      = (linkloop == LL_LOOP);
   assign mode_chg    = (linkloop != linkloop_q);
   assign unused_ctrl = ^bus.act_inact_ctrl[7:6];

   // Linked/loop: only the detector that can leave the current state runs;
   // linked additionally waits for the host to acknowledge the last event.
   always_comb begin
      act_eval   = bus.act_inact_ctrl[AIC_ACT_EN];
      inact_eval = bus.act_inact_ctrl[AIC_INACT_EN];
      if (linked || looped) begin
         if (state == S_AWAKE) act_eval   = 1'b0;
         else                  inact_eval = 1'b0;
         if (linked && ((state == S_AWAKE) ? act_q : inact_q)) begin
            act_eval   = 1'b0;
            inact_eval = 1'b0;
         end
      end
   end

   adxl362_event_counter #(.CNT_W(8), .DETECT_ABOVE(1'b1)) u_act (
      .clk_16mhz    (clk_16mhz),
      .reset_n      (reset_n),
      .sample_valid (bus.sample_valid),
      .xdata        (bus.xdata),
      .ydata        (bus.ydata),
      .zdata        (bus.zdata),
      .threshold    (bus.threshold_active),
      .time_req     (bus.time_active),
      .enable       (bus.act_inact_ctrl[AIC_ACT_EN]),
      .evaluate     (act_eval),
      .clear        (mode_chg),
      .ref_mode     (bus.act_inact_ctrl[AIC_ACT_REF]),
      .event_pulse  (act_evt)
   );

   adxl362_event_counter #(.CNT_W(16), .DETECT_ABOVE(1'b0)) u_inact (
      .clk_16mhz    (clk_16mhz),
      .reset_n      (reset_n),
      .sample_valid (bus.sample_valid),
      .xdata        (bus.xdata),
      .ydata        (bus.ydata),
      .zdata        (bus.zdata),
      .threshold    (bus.threshold_inactive),
      .time_req     (bus.time_inactive),
      .enable       (bus.act_inact_ctrl[AIC_INACT_EN]),
      .evaluate     (inact_eval),
      .clear        (mode_chg),
      .ref_mode     (bus.act_inact_ctrl[AIC_INACT_REF]),
      .event_pulse  (inact_evt)
   );

   // A set beats a same-cycle status read; the read still clears the other flag.
   always_comb begin
      state_nxt = state;
      act_nxt   = act_q;
      inact_nxt = inact_q;
      if (bus.status_read) begin
         act_nxt   = 1'b0;
         inact_nxt = 1'b0;
      end
      if (act_evt) begin
         act_nxt = 1'b1;
         if (looped) inact_nxt = 1'b0;
      end
      if (inact_evt) begin
         inact_nxt = 1'b1;
         if (looped) act_nxt = 1'b0;
      end
      if (mode_chg || !(linked || looped)) state_nxt = S_AWAKE;
      else if (inact_evt)                  state_nxt = S_ASLEEP;
      else if (act_evt)                    state_nxt = S_AWAKE;
   end

   always_ff @(posedge clk_16mhz) begin
      if (!reset_n) begin
         state      <= S_AWAKE;
         act_q      <= 1'b0;
         inact_q    <= 1'b0;
         linkloop_q <= linkloop;
         int1_q     <= bus.intmap1[IM_INT_LOW];
         int2_q     <= bus.intmap2[IM_INT_LOW];
      end else begin
         state      <= state_nxt;
         act_q      <= act_nxt;
         inact_q    <= inact_nxt;
         linkloop_q <= linkloop;
         int1_q     <= irq_level(bus.intmap1, bus.data_ready, act_q, inact_q, state == S_AWAKE);
         int2_q     <= irq_level(bus.intmap2, bus.data_ready, act_q, inact_q, state == S_AWAKE);
      end
   end

   assign bus.act_flag   = act_q;
   assign bus.inact_flag = inact_q;
   assign bus.awake      = (state == S_AWAKE);
   assign bus.int1       = int1_q;
   assign bus.int2       = int2_q;

endmodule

// File: tb/tb_adxl362_activity_ctrl.sv
// Directed plus randomized bench for adxl362_activity_ctrl against a sample-level reference model.
module tb_adxl362_activity_ctrl;
   logic clk_16mhz = 1'b0;
   logic reset_n   = 1'b0;
   int   n_assert  = 0;
   int   n_fail    = 0;

   adxl362_activity_ctrl_if ifc();
   adxl362_activity_ctrl dut (.clk_16mhz(clk_16mhz), .reset_n(reset_n), .bus(ifc));

   always #31 clk_16mhz = ~clk_16mhz;

   // reference model state
   int       m_acnt, m_icnt;
   bit       m_act, m_inact, m_int1, m_int2;
   bit       m_awake = 1'b1;
   bit [1:0] m_ll;

   function automatic int iabs(logic [11:0] v);
      int s;
      s = $signed(v);
      return (s < 0) ? -s : s;
   endfunction

   function automatic bit m_irq(logic [7:0] im);
      bit raw;
      raw = (im[0] & ifc.data_ready) | (im[4] & m_act) | (im[5] & m_inact) | (im[6] & m_awake);
      return raw ^ im[7];
   endfunction

   task automatic model_edge();
      int  ax, ay, az, ta, ti, mode;
      bit  a_ok, i_ok, is_act, is_inact, a_ev, i_ev, n1, n2;
      bit [1:0] ll;
      if (!reset_n) begin
         m_acnt = 0; m_icnt = 0; m_act = 0; m_inact = 0; m_awake = 1;
         m_ll   = ifc.act_inact_ctrl[5:4];
         m_int1 = ifc.intmap1[7];
         m_int2 = ifc.intmap2[7];
         return;
      end
      n1 = m_irq(ifc.intmap1);
      n2 = m_irq(ifc.intmap2);
      ll   = ifc.act_inact_ctrl[5:4];
      mode = (ll == 2'b01) ? 1 : (ll == 2'b11) ? 2 : 0;
      a_ok = ifc.act_inact_ctrl[0];
      i_ok = ifc.act_inact_ctrl[2];
      if (mode == 1) begin
         a_ok = a_ok && !m_awake && !m_inact;
         i_ok = i_ok && m_awake && !m_act;
      end else if (mode == 2) begin
         a_ok = a_ok && !m_awake;
         i_ok = i_ok && m_awake;
      end
      if (ll != m_ll) begin a_ok = 0; i_ok = 0; end
      ax = iabs(ifc.xdata); ay = iabs(ifc.ydata); az = iabs(ifc.zdata);
      ta = int'(ifc.threshold_active);
      ti = int'(ifc.threshold_inactive);
      is_act   = (ax > ta) || (ay > ta) || (az > ta);
      is_inact = (ax < ti) && (ay < ti) && (az < ti);
      a_ev = 0; i_ev = 0;
      if (!a_ok) m_acnt = 0;
      else if (ifc.sample_valid) begin
         if (is_act) begin
            m_acnt = (m_acnt + 1 > 255) ? 255 : m_acnt + 1;
            if (m_acnt >= ((ifc.time_active == 0) ? 1 : int'(ifc.time_active))) begin
               a_ev = 1; m_acnt = 0;
            end
         end else m_acnt = 0;
      end
      if (!i_ok) m_icnt = 0;
      else if (ifc.sample_valid) begin
         if (is_inact) begin
            m_icnt = (m_icnt + 1 > 65535) ? 65535 : m_icnt + 1;
            if (m_icnt >= ((ifc.time_inactive == 0) ? 1 : int'(ifc.time_inactive))) begin
               i_ev = 1; m_icnt = 0;
            end
         end else m_icnt = 0;
      end
      if (ifc.status_read) begin
         if (!a_ev) m_act   = 0;
         if (!i_ev) m_inact = 0;
      end
      if (a_ev) begin m_act = 1;   if (mode == 2) m_inact = 0; end
      if (i_ev) begin m_inact = 1; if (mode == 2) m_act   = 0; end
      if (ll != m_ll || mode == 0) m_awake = 1;
      else if (i_ev)               m_awake = 0;
      else if (a_ev)               m_awake = 1;
      m_ll   = ll;
      m_int1 = n1;
      m_int2 = n2;
   endtask

   task automatic chk(string tag, logic obs, logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_16mhz);
      model_edge();
      #1;
      chk("act_flag",   ifc.act_flag,   m_act);
      chk("inact_flag", ifc.inact_flag, m_inact);
      chk("awake",      ifc.awake,      m_awake);
      chk("int1",       ifc.int1,       m_int1);
      chk("int2",       ifc.int2,       m_int2);
   endtask

   task automatic sample(int x, int y, int z, bit sr = 1'b0);
      ifc.sample_valid = 1'b1;
      ifc.xdata        = x[11:0];
      ifc.ydata        = y[11:0];
      ifc.zdata        = z[11:0];
      ifc.status_read  = sr;
      cyc();
      ifc.sample_valid = 1'b0;
      ifc.status_read  = 1'b0;
   endtask

   task automatic ack();
      ifc.status_read = 1'b1;
      cyc();
      ifc.status_read = 1'b0;
   endtask

   initial begin
      logic [7:0] modes [3];
      int v [3];
      bit loud;
      modes = '{8'h05, 8'h15, 8'h35};
      ifc.sample_valid = 0; ifc.xdata = 0; ifc.ydata = 0; ifc.zdata = 0;
      ifc.threshold_active = 11'd100; ifc.time_active = 8'd3;
      ifc.threshold_inactive = 11'd20; ifc.time_inactive = 16'd0;
      ifc.act_inact_ctrl = 8'h00; ifc.intmap1 = 8'h00; ifc.intmap2 = 8'h00;
      ifc.data_ready = 0; ifc.status_read = 0;

      // reset state
      cyc(); cyc();
      chk("rst_act", ifc.act_flag, 1'b0);
      chk("rst_awake", ifc.awake, 1'b1);
      chk("rst_int1", ifc.int1, 1'b0);

      // default-mode activity, strict compare
      reset_n = 1'b1;
      ifc.act_inact_ctrl = 8'h01; ifc.intmap1 = 8'h10;
      cyc();
      sample(101, 0, 0); sample(101, 0, 0);
      chk("act_after2", ifc.act_flag, 1'b0);
      sample(101, 0, 0);
      chk("act_after3", ifc.act_flag, 1'b1);
      chk("int1_lag", ifc.int1, 1'b0);
      cyc();
      chk("int1_set", ifc.int1, 1'b1);
      ack();
      for (int i = 0; i < 5; i++) begin
         sample(100, 0, 0);
         chk("act_eq_thr", ifc.act_flag, 1'b0);
      end

      // inactivity, time 0
      ifc.act_inact_ctrl = 8'h04;
      cyc();
      sample(10, 10, 10);
      chk("inact_t0", ifc.inact_flag, 1'b1);
      ack();

      // linked mode
      ifc.act_inact_ctrl = 8'h15; ifc.time_active = 8'd2;
      cyc();
      sample(5, 5, 5);
      chk("lnk_inact", ifc.inact_flag, 1'b1);
      chk("lnk_sleep", ifc.awake, 1'b0);
      for (int i = 0; i < 3; i++) begin
         sample(500, 0, 0);
         chk("lnk_ignored", ifc.act_flag, 1'b0);
      end
      ack();
      sample(500, 0, 0);
      chk("lnk_act1", ifc.act_flag, 1'b0);
      sample(500, 0, 0);
      chk("lnk_act2", ifc.act_flag, 1'b1);
      chk("lnk_wake", ifc.awake, 1'b1);

      // loop mode
      ifc.act_inact_ctrl = 8'h35;
      cyc();
      sample(5, 5, 5);
      chk("loop_sleep", ifc.awake, 1'b0);
      chk("loop_clr_act", ifc.act_flag, 1'b0);
      sample(500, 0, 0); sample(500, 0, 0);
      chk("loop_wake", ifc.awake, 1'b1);
      chk("loop_clr_inact", ifc.inact_flag, 1'b0);
      sample(5, 5, 5);
      chk("loop_sleep2", ifc.awake, 1'b0);

      // simultaneous event + status_read, -2048 magnitude
      ifc.act_inact_ctrl = 8'h05; ifc.threshold_active = 11'd2047; ifc.time_active = 8'd0;
      cyc();
      sample(-2048, 0, 0, 1'b1);
      chk("sim_act", ifc.act_flag, 1'b1);
      chk("sim_inact_clr", ifc.inact_flag, 1'b0);
      ack();
      sample(2047, 0, 0);
      chk("max_not_act", ifc.act_flag, 1'b0);

      // INT_LOW idle level and reset mid-count
      ifc.act_inact_ctrl = 8'h01; ifc.threshold_active = 11'd100; ifc.time_active = 8'd3;
      ifc.intmap1 = 8'h80;
      cyc(); cyc();
      chk("int_low_idle", ifc.int1, 1'b1);
      sample(101, 0, 0); sample(101, 0, 0);
      reset_n = 1'b0; cyc();
      reset_n = 1'b1;
      sample(101, 0, 0); sample(101, 0, 0);
      chk("rst_fresh2", ifc.act_flag, 1'b0);
      sample(101, 0, 0);
      chk("rst_fresh3", ifc.act_flag, 1'b1);
      ack();

      // randomized run in each mode
      for (int m = 0; m < 3; m++) begin
         ifc.act_inact_ctrl     = modes[m];
         ifc.threshold_active   = 11'($urandom_range(100, 600));
         ifc.threshold_inactive = 11'($urandom_range(50, 150));
         ifc.time_active        = 8'($urandom_range(0, 3));
         ifc.time_inactive      = 16'($urandom_range(0, 3));
         ifc.intmap1            = 8'($urandom);
         ifc.intmap2            = 8'($urandom);
         cyc();
         for (int n = 0; n < 300; n++) begin
            loud = ($urandom_range(0, 1) == 1);
            for (int a = 0; a < 3; a++)
               v[a] = loud ? int'($urandom_range(0, 4095)) - 2048
                           : int'($urandom_range(0, 80)) - 40;
            ifc.xdata = v[0][11:0]; ifc.ydata = v[1][11:0]; ifc.zdata = v[2][11:0];
            ifc.sample_valid = ($urandom_range(0, 1) == 1);
            ifc.status_read  = ($urandom_range(0, 5) == 0);
            ifc.data_ready   = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 15) == 0) ifc.intmap1 = 8'($urandom);
            cyc();
         end
         ifc.sample_valid = 1'b0;
         ifc.status_read  = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
